// File: rtl/hept_stage_sequencer.sv
// -----------------------------------------------------------------------------
// hept_stage_sequencer
//
// Runs the HEPT kernel sub-stages (transpose_qk, pairwise_dist_sq_rbf,
// mask_and_normalize, transpose_output) strictly in order for every batch
// item of one top-level ap_ctrl_hs transaction. It records per-stage and
// per-transaction cycle counts, and it aborts with a sticky error when a
// stage exceeds the watchdog limit.
//
// Handshake (ap_ctrl_hs, both towards the host and towards each stage):
//   - The start line stays high until the matching ready is seen.
//   - ready marks acceptance of the start. done marks completion and may
//     coincide with ready.
//   - Towards the host, ap_done and ap_ready are the same one-cycle pulse.
//     ap_start is only looked at while idle.
//   - Towards stage k, stage_start[k] is high only while that stage is being
//     issued. ready/done bits of any other stage are ignored. A stage_done
//     without stage_ready during issue is ignored.
//
// Ports:
//   ap_clk, ap_rst       clock, asynchronous active-high reset
//   ap_start             top-level start (held until ap_ready)
//   ap_done, ap_ready    one-cycle end-of-transaction pulse
//   ap_idle              high while idle
//   stage_start          one-hot start to the active stage
//   stage_ready          per-stage ap_ready
//   stage_done           per-stage ap_done
//   stage_idx            active stage index
//   batch_idx            active batch item index
//   last_stage_cycles    ISSUE+WAIT cycles of the most recently finished stage
//   total_cycles         non-idle cycles of the current or last transaction
//   err_timeout          sticky watchdog error
//   err_stage            stage index that tripped the watchdog
//   dbg_state            current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module hept_stage_sequencer #(
    parameter int N_STAGES       = 4,
    parameter int BATCH          = 2,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 0,
    localparam int SW            = (N_STAGES > 1) ? $clog2(N_STAGES) : 1,
    localparam int BW            = (BATCH > 1) ? $clog2(BATCH) : 1
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                ap_start,
    output logic                ap_done,
    output logic                ap_idle,
    output logic                ap_ready,
    output logic [N_STAGES-1:0] stage_start,
    input  logic [N_STAGES-1:0] stage_ready,
    input  logic [N_STAGES-1:0] stage_done,
    output logic [SW-1:0]       stage_idx,
    output logic [BW-1:0]       batch_idx,
    output logic [CNT_W-1:0]    last_stage_cycles,
    output logic [CNT_W-1:0]    total_cycles,
    output logic                err_timeout,
    output logic [SW-1:0]       err_stage,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_ADVANCE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    // The watchdog fires on the edge where the stage counter would reach the
    // limit, so the comparison is against limit-1 before the increment.
    localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit               WD_ENABLE  = (TIMEOUT_CYCLES != 0);
    localparam logic [SW-1:0]    LAST_STAGE = SW'(N_STAGES - 1);
    localparam logic [BW-1:0]    LAST_BATCH = BW'(BATCH - 1);

    state_t           state;
    logic [CNT_W-1:0] stage_cnt;

    logic             act_ready;
    logic             act_done;
    logic             wd_hit;
    logic [CNT_W-1:0] stage_cnt_inc;

    // Only the active stage's handshake bits are looked at.
    assign act_ready     = stage_ready[stage_idx];
    assign act_done      = stage_done[stage_idx];
    assign wd_hit        = WD_ENABLE && (stage_cnt == WD_LAST);
    assign stage_cnt_inc = (stage_cnt == CNT_MAX) ? stage_cnt : stage_cnt + 1'b1;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state             <= S_IDLE;
            stage_idx         <= '0;
            batch_idx         <= '0;
            stage_cnt         <= '0;
            last_stage_cycles <= '0;
            total_cycles      <= '0;
            err_timeout       <= 1'b0;
            err_stage         <= '0;
        end else begin
            // Counts every non-idle cycle; the IDLE branch below restarts it.
            if (state != S_IDLE && total_cycles != CNT_MAX) begin
                total_cycles <= total_cycles + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        state        <= S_ISSUE;
                        stage_idx    <= '0;
                        batch_idx    <= '0;
                        stage_cnt    <= '0;
                        total_cycles <= '0;
                        err_timeout  <= 1'b0;
                        err_stage    <= '0;
                    end
                end

                S_ISSUE: begin
                    stage_cnt <= stage_cnt_inc;
                    if (wd_hit) begin
                        err_timeout <= 1'b1;
                        err_stage   <= stage_idx;
                        state       <= S_DONE;
                    end else if (act_ready) begin
                        state <= act_done ? S_ADVANCE : S_WAIT;
                    end
                end

                S_WAIT: begin
                    stage_cnt <= stage_cnt_inc;
                    if (wd_hit) begin
                        err_timeout <= 1'b1;
                        err_stage   <= stage_idx;
                        state       <= S_DONE;
                    end else if (act_done) begin
                        state <= S_ADVANCE;
                    end
                end

                S_ADVANCE: begin
                    last_stage_cycles <= stage_cnt;
                    stage_cnt         <= '0;
                    if (stage_idx == LAST_STAGE && batch_idx == LAST_BATCH) begin
                        state <= S_DONE;
                    end else if (stage_idx == LAST_STAGE) begin
                        stage_idx <= '0;
                        batch_idx <= batch_idx + 1'b1;
                        state     <= S_ISSUE;
                    end else begin
                        stage_idx <= stage_idx + 1'b1;
                        state     <= S_ISSUE;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs depend on registers only, never on inputs.
    always_comb begin
        stage_start = '0;
        if (state == S_ISSUE) begin
            stage_start[stage_idx] = 1'b1;
        end
    end

    assign ap_idle   = (state == S_IDLE);
    assign ap_done   = (state == S_DONE);
    assign ap_ready  = (state == S_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_hept_stage_sequencer.sv
module tb_hept_stage_sequencer;

  localparam int N  = 4;
  localparam int B  = 2;
  localparam int TO = 10;

  // Per-stage response delays counted from the first ISSUE cycle of a stage.
  typedef struct packed {
    logic [3:0][4:0] rdy;
    logic [3:0][4:0] dn;
    logic            hang_en;
    logic [1:0]      hang_s;
    logic            hang_b;
    logic            spur;
    logic [7:0]      exp_done;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [3:0]  stage_start;
  logic [3:0]  stage_ready;
  logic [3:0]  stage_done;
  logic [1:0]  stage_idx;
  logic [0:0]  batch_idx;
  logic [31:0] last_stage_cycles;
  logic [31:0] total_cycles;
  logic        err_timeout;
  logic [1:0]  err_stage;
  logic [2:0]  dbg_state;

  logic [3:0]  env_ready, env_done, spur_ready, spur_done;
  assign stage_ready = env_ready | spur_ready;
  assign stage_done  = env_done | spur_done;

  int n_total;
  int n_bad;

  hept_stage_sequencer #(
    .N_STAGES(N), .BATCH(B), .CNT_W(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .ap_clk(clk), .ap_rst(rst), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .stage_start(stage_start), .stage_ready(stage_ready), .stage_done(stage_done),
    .stage_idx(stage_idx), .batch_idx(batch_idx),
    .last_stage_cycles(last_stage_cycles), .total_cycles(total_cycles),
    .err_timeout(err_timeout), .err_stage(err_stage), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stage environment ----------------
  vec_t cfg;
  bit   env_busy;
  int   env_s, env_age, env_b;

  always @(negedge clk) begin
    env_ready = '0;
    env_done  = '0;
    if (!env_busy && stage_start != 4'b0) begin
      env_busy = 1'b1;
      env_age  = 0;
      for (int i = 0; i < N; i++) if (stage_start[i]) env_s = i;
    end
    if (env_busy) begin
      if (env_age == int'(cfg.rdy[env_s])) env_ready[env_s] = 1'b1;
      if (env_age == int'(cfg.dn[env_s]) &&
          !(cfg.hang_en && int'(cfg.hang_s) == env_s && int'(cfg.hang_b) == env_b)) begin
        env_done[env_s] = 1'b1;
        env_busy = 1'b0;
        if (env_s == N - 1) env_b++;
      end
      env_age++;
    end
  end

  task automatic env_reset();
    env_busy   = 1'b0;
    env_age    = 0;
    env_b      = 0;
    env_s      = 0;
    env_ready  = '0;
    env_done   = '0;
    spur_ready = '0;
    spur_done  = '0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference timeline: each stage occupies len cycles of ISSUE/WAIT
  // (start high for the first iss of them) followed by one ADVANCE cycle;
  // a hung stage occupies exactly TO cycles and ends the transaction.
  logic [3:0] exp_start[80];
  int         exp_lsc[80];
  int         exp_sidx[80];
  int         exp_bidx[80];

  function automatic int build_model(input vec_t v);
    int c, len, iss;
    bit hung;
    for (int i = 0; i < 80; i++) begin
      exp_start[i] = '0;
      exp_lsc[i]   = -1;
      exp_sidx[i]  = -1;
      exp_bidx[i]  = -1;
    end
    c = 1;
    for (int b = 0; b < B; b++) begin
      for (int s = 0; s < N; s++) begin
        hung = v.hang_en && int'(v.hang_s) == s && int'(v.hang_b) == b;
        len  = hung ? TO : int'(v.dn[s]) + 1;
        iss  = int'(v.rdy[s]) + 1;
        if (iss > len) iss = len;
        for (int k = 0; k < len; k++) begin
          exp_start[c + k] = (k < iss) ? 4'(1 << s) : 4'b0;
          exp_sidx[c + k]  = s;
          exp_bidx[c + k]  = b;
        end
        c += len;
        if (hung) return c;
        exp_lsc[c + 1] = len;
        c += 1;
      end
    end
    return c;
  endfunction

  // ---------------- driver ----------------
  task automatic run_txn(input vec_t v, input string tag);
    int dc, obs_done;
    logic [31:0] tot_at_done;
    @(posedge clk); #1;
    cfg = v;
    env_reset();
    dc = build_model(v);
    @(negedge clk);
    chk($sformatf("%s idle_c0", tag), ap_idle, 1);
    ap_start = 1'b1;
    obs_done = 0;
    tot_at_done = '0;
    for (int c = 1; c <= dc + 1; c++) begin
      @(negedge clk);
      ap_start   = v.spur && c == 5;
      spur_ready = (v.spur && c == 1) ? 4'b1110 : 4'b0000;
      spur_done  = (v.spur && c == 1) ? 4'b1000 : 4'b0000;
      chk($sformatf("%s start c%0d", tag, c), stage_start, exp_start[c]);
      chk($sformatf("%s done c%0d", tag, c), ap_done, c == dc);
      chk($sformatf("%s ready c%0d", tag, c), ap_ready, c == dc);
      chk($sformatf("%s idle c%0d", tag, c), ap_idle, c > dc);
      if (exp_sidx[c] >= 0) begin
        chk($sformatf("%s sidx c%0d", tag, c), stage_idx, exp_sidx[c]);
        chk($sformatf("%s bidx c%0d", tag, c), batch_idx, exp_bidx[c]);
      end
      if (exp_lsc[c] >= 0)
        chk($sformatf("%s lsc c%0d", tag, c), last_stage_cycles, exp_lsc[c]);
      chk($sformatf("%s err c%0d", tag, c), err_timeout, v.hang_en && c >= dc);
      chk($sformatf("%s err_stage c%0d", tag, c), err_stage,
          (v.hang_en && c >= dc) ? v.hang_s : 2'd0);
      if (ap_done && obs_done == 0) begin
        obs_done = c;
        tot_at_done = total_cycles;
      end
    end
    chk($sformatf("%s total_idle", tag), total_cycles, dc);
    if (v.exp_done != 0) begin
      chk($sformatf("%s done_cycle", tag), obs_done, v.exp_done);
      chk($sformatf("%s total_at_done", tag), tot_at_done, v.exp_done - 1);
    end
  endtask

  // ---------------- test ----------------
  vec_t tbl[6];

  initial begin
    vec_t v;
    int c, d1, d2;
    n_total  = 0;
    n_bad    = 0;
    rst      = 1'b1;
    ap_start = 1'b0;
    cfg      = '0;
    env_reset();

    tbl[0] = '0; tbl[0].exp_done = 17;
    tbl[1] = '0; tbl[1].rdy[1] = 2; tbl[1].dn[1] = 5; tbl[1].exp_done = 27;
    tbl[2] = '0; tbl[2].spur = 1'b1; tbl[2].exp_done = 17;
    tbl[3] = '0; tbl[3].hang_en = 1'b1; tbl[3].hang_s = 2; tbl[3].hang_b = 1;
    tbl[3].exp_done = 23;
    tbl[4] = '0; tbl[4].rdy[0] = 1; tbl[4].dn[0] = 3; tbl[4].rdy[2] = 2;
    tbl[4].dn[2] = 2; tbl[4].dn[3] = 1; tbl[4].exp_done = 29;
    tbl[5] = '0; tbl[5].hang_en = 1'b1; tbl[5].hang_s = 0; tbl[5].hang_b = 0;
    tbl[5].rdy[0] = 15; tbl[5].exp_done = 11;

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    chk("rst idle", ap_idle, 1);
    chk("rst done", ap_done, 0);
    chk("rst start", stage_start, 0);
    chk("rst total", total_cycles, 0);
    chk("rst lsc", last_stage_cycles, 0);
    chk("rst err", err_timeout, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Error flag persists in idle, reset clears it.
    repeat (3) @(negedge clk);
    chk("err_sticky_idle", err_timeout, 1);
    #2 rst = 1'b1;
    #1;
    chk("err_cleared_by_rst", err_timeout, 0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset while waiting on stage 2, batch 0.
    @(posedge clk); #1;
    v = '0; v.hang_en = 1'b1; v.hang_s = 2; v.hang_b = 0;
    cfg = v;
    env_reset();
    @(negedge clk);
    ap_start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      ap_start = 1'b0;
    end
    chk("mid_wait sidx", stage_idx, 2);
    chk("mid_wait start", stage_start, 0);
    chk("mid_wait busy", ap_idle, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst idle", ap_idle, 1);
    chk("arst done", ap_done, 0);
    chk("arst ready", ap_ready, 0);
    chk("arst start", stage_start, 0);
    chk("arst sidx", stage_idx, 0);
    chk("arst bidx", batch_idx, 0);
    chk("arst total", total_cycles, 0);
    chk("arst lsc", last_stage_cycles, 0);
    chk("arst err", err_timeout, 0);
    chk("arst err_stage", err_stage, 0);
    @(negedge clk);
    rst = 1'b0;
    run_txn(tbl[0], "after_rst");

    // ap_start held high across two transactions.
    @(posedge clk); #1;
    cfg = '0;
    env_reset();
    @(negedge clk);
    ap_start = 1'b1;
    c = 0; d1 = 0; d2 = 0;
    while (d2 == 0 && c < 80) begin
      @(negedge clk);
      c++;
      if (c == 19) ap_start = 1'b0;
      if (ap_done) begin
        if (d1 == 0) d1 = c;
        else d2 = c;
      end
    end
    chk("b2b first_done", d1, 17);
    chk("b2b interval", d2 - d1, 18);
    @(negedge clk);
    chk("b2b idle_after", ap_idle, 1);

    // Randomized delays, occasionally with a hung stage.
    for (int r = 0; r < 20; r++) begin
      v = '0;
      for (int s = 0; s < N; s++) begin
        v.rdy[s] = 5'($urandom_range(0, 2));
        v.dn[s]  = v.rdy[s] + 5'($urandom_range(0, 2));
      end
      v.hang_en = ($urandom_range(0, 3) == 0);
      v.hang_s  = 2'($urandom_range(0, 3));
      v.hang_b  = 1'($urandom_range(0, 1));
      run_txn(v, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/hept_stage_sequencer.md
# hept_stage_sequencer

Sequences the HEPT kernel sub-stages inside `myproject` through their `ap_ctrl_hs` handshakes. The stages are transpose_qk, pairwise_dist_sq_rbf, mask_and_normalize and transpose_output. For each batch item, the sequencer runs the stages strictly in order. It exposes a top-level `ap_ctrl_hs` interface, records per-stage cycle counts for profiling, and aborts with a sticky error if a stage hangs past a watchdog limit.

## Interface
- `N_STAGES`, default 4: number of sequenced stages; index 0 runs first.
- `BATCH`, default 2: batch items processed per `ap_start` transaction.
- `CNT_W`, default 32: width of the cycle counters.
- `TIMEOUT_CYCLES`, default 0: watchdog limit per stage; 0 disables the watchdog.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `ap_clk`  in  1  clock.
- `ap_rst`  in  1  asynchronous, active-high reset.
- `ap_start`  in  1  top-level start, held high until `ap_ready`.
- `ap_done`  out  1  one-cycle pulse at the end of a transaction.
- `ap_idle`  out  1  high while in IDLE.
- `ap_ready`  out  1  one-cycle pulse, coincident with `ap_done`.
- `stage_start`  out  N_STAGES  one-hot start to the active stage.
- `stage_ready`  in  N_STAGES  stage ap_ready per stage.
- `stage_done`  in  N_STAGES  stage ap_done per stage.
- `stage_idx`  out  clog2(N_STAGES)  active stage index.
- `batch_idx`  out  clog2(BATCH)  active batch item index.
- `last_stage_cycles`  out  CNT_W  cycle count of the most recently completed stage.
- `total_cycles`  out  CNT_W  cycle count of the current or last transaction.
- `err_timeout`  out  1  sticky watchdog error flag.
- `err_stage`  out  clog2(N_STAGES)  index of the stage that timed out.

## Operation
- **States:** IDLE, ISSUE, WAIT, ADVANCE, DONE. All states are registered.
- **IDLE:** `ap_idle`=1.
  - `ap_start`=1 → ISSUE.
  - On the same edge: `stage_idx`=0, `batch_idx`=0; clear `total_cycles`, `err_timeout` and `err_stage`.
- **ISSUE:** `stage_start[stage_idx]`=1.
  - On `stage_ready[stage_idx]`=1 → WAIT.
  - If `stage_done[stage_idx]`=1 in the same cycle, go straight to ADVANCE.
  - `stage_done` without `stage_ready` is ignored.
- **WAIT:** `stage_start` is all zero.
  - `stage_done[stage_idx]`=1 → ADVANCE.
- **ADVANCE:** latch `last_stage_cycles` = stage counter value (cycles spent in ISSUE+WAIT for the stage just finished, ≥1), then branch:
  - Last stage of last batch item (`stage_idx`=N_STAGES-1 and `batch_idx`=BATCH-1) → DONE.
  - Otherwise, if `stage_idx`=N_STAGES-1: `stage_idx` wraps to 0, `batch_idx`+1 → ISSUE.
  - Otherwise: `stage_idx`+1 → ISSUE.
- **DONE:** `ap_done`=1 and `ap_ready`=1 for one cycle → IDLE.
- **Ignored inputs:**
  - `stage_ready`/`stage_done` bits of non-active stages are ignored in all states.
  - `ap_start` is ignored outside IDLE.
- **Stage counter:** clears on entry to ISSUE and increments in ISSUE and WAIT. Both counters saturate at 2^CNT_W-1.
- **`total_cycles`:** increments in every non-IDLE state and holds its value in IDLE.
- **Watchdog** (TIMEOUT_CYCLES≠0): when the stage counter reaches TIMEOUT_CYCLES in ISSUE or WAIT:
  - Set `err_timeout`=1 and `err_stage`=`stage_idx`.
  - Go directly to DONE; the remaining stages are skipped.
  - `stage_start` deasserts on that edge.
- **Asynchronous reset**, in any state including mid-transaction:
  - State = IDLE; `ap_idle`=1.
  - All other outputs are 0: `ap_done`, `ap_ready`, `stage_start`, `stage_idx`, `batch_idx`, both counters, `err_timeout`, `err_stage`.

## Timing
- Output timing:
  - `stage_start`, `ap_done`, `ap_ready` and `ap_idle` are decoded from the state register only; there is no combinational path from inputs.
  - `stage_idx` and `batch_idx` are registered.
- Latency:
  - Start: `ap_start` is sampled in IDLE at cycle 0; `stage_start[0]` is high in cycle 1.
  - Per stage, zero-wait case (ready+done in the first ISSUE cycle): 2 cycles (ISSUE, ADVANCE).
  - Minimum transaction: `ap_done` in cycle 1+2·N_STAGES·BATCH; 17 at defaults.
  - General case: each stage adds (cycles in ISSUE+WAIT)+1.
- Back-to-back transactions:
  - After DONE the block spends at least one IDLE cycle.
  - `ap_start` held high is re-accepted in that IDLE cycle, giving a minimum start-to-start interval of 2+2·N·B cycles.
- `err_timeout` persists through DONE and IDLE until the next accepted `ap_start` or reset.

## Test plan
- **Zero-wait stages, defaults:** all stages tie ready=done=1.
  - Pulse `ap_start`.
  - Expect `stage_start` one-hot sequence 1,2,4,8,1,2,4,8 on cycles 1,3,…,15.
  - Expect `ap_done`=`ap_ready`=1 only at cycle 17, and `total_cycles`=16.
- **Stage 1 with ready at +2 and done at +5 after its start:**
  - Expect `last_stage_cycles`=6 after stage 1.
  - Expect `stage_start[1]` high for exactly 3 cycles.
  - Expect `ap_done` at cycle 27.
- **Spurious inputs:** `stage_done[3]` pulsed while stage 0 is active, and `ap_start` pulsed mid-transaction.
  - Expect no state change; the sequence and done cycle are identical to the zero-wait test.
- **Watchdog:** TIMEOUT_CYCLES=10, stage 2 never asserts done on batch 1.
  - Expect `err_timeout`=1 and `err_stage`=2.
  - Expect `ap_done` one cycle after the 10th counted cycle, and stage 3 never started.
  - The next `ap_start` clears `err_timeout`.
- **Reset mid-operation:** assert `ap_rst` asynchronously while in WAIT on stage 2, batch 0.
  - Expect immediately: all outputs 0 and `ap_idle`=1.
  - A subsequent `ap_start` runs the full sequence from stage 0, batch 0.
- **`ap_start` held high across two transactions (zero-wait):** expect a second `ap_done` exactly 18 cycles after the first.
